// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC drives dr combinationally, fetched word registered into IF/ID (1-cycle latency).
// stall holds PC and IF/ID; br_en redirects and flushes; IF_FETCH_CNT_EN builds the delivery counter.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_en,
  input  logic [31:0] br_tgt,
  input  logic [31:0] ins,
  output logic [31:0] dr,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        addr_err,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [32:0] pc_last_byte;
  logic        out_of_range;

  // Last byte of the word computed in 33 bits so a PC near 2^32 cannot wrap into range.
  assign pc_last_byte = {1'b0, pc} + 33'd3;
  assign out_of_range = (pc_last_byte >= 33'(MEM_BYTES));

  assign dr     = pc;
  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      if_ins   <= 32'h0;
      if_pc    <= 32'h0;
      if_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (br_en) begin
      // Redirect wins in both states and over stall; the word at the old PC is wrong-path.
      state    <= RUN;
      pc       <= {br_tgt[31:2], 2'b00};
      if_valid <= 1'b0;
      addr_err <= (br_tgt[1:0] != 2'b00);
    end else begin
      case (state)
        RUN: begin
          if (out_of_range) begin
            state    <= HALT;
            if_valid <= 1'b0;
            addr_err <= 1'b1;
          end else if (stall) begin
            addr_err <= 1'b0;
          end else begin
            if_ins   <= ins;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 32'd4;
            addr_err <= 1'b0;
          end
        end
        HALT: begin
          if_valid <= 1'b0;
          addr_err <= 1'b0;
        end
        default: begin
          state    <= HALT;
          if_valid <= 1'b0;
          addr_err <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic        deliver;
  logic [31:0] cnt;

  assign deliver = (state == RUN) && !br_en && !out_of_range && !stall;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 32'h0;
    else if (deliver)
      cnt <= cnt + 32'd1;
  end

  assign fetch_cnt = cnt;
`else
  assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a combinational word-array instruction memory.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, br_en;
  logic [31:0] br_tgt, ins;
  logic [31:0] dr, if_ins, if_pc, fetch_cnt;
  logic        if_valid, addr_err, halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  assign ins = (dr < 32'd1024) ? mem[dr[9:2]] : 32'hBAD0_BAD0;

  if_fetch_stage #(.RESET_PC(32'h0), .MEM_BYTES(1000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_tgt(br_tgt), .ins(ins),
    .dr(dr), .if_ins(if_ins), .if_pc(if_pc), .if_valid(if_valid),
    .addr_err(addr_err), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef IF_FETCH_CNT_EN
    return n;
`else
    return 32'h0 & n;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br_en = 1'b0; br_tgt = 32'h0;
    step(); step();
    total++; if (dr !== 32'h0) begin bad++; $display("FAIL reset_dr got=%h exp=%h", dr, 32'h0); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
    total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", fetch_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    step();
    total++; if (if_ins !== 32'h1111_1111 || if_pc !== 32'h0 || if_valid !== 1'b1)
      begin bad++; $display("FAIL seq_first got ins=%h pc=%h v=%b exp 11111111/0/1", if_ins, if_pc, if_valid); end
    step();
    total++; if (if_ins !== 32'h2222_2222 || if_pc !== 32'h4 || if_valid !== 1'b1)
      begin bad++; $display("FAIL seq_second got ins=%h pc=%h v=%b exp 22222222/4/1", if_ins, if_pc, if_valid); end
    total++; if (dr !== 32'h8) begin bad++; $display("FAIL seq_dr got=%h exp=8", dr); end
    total++; if (fetch_cnt !== cnt_exp(2)) begin bad++; $display("FAIL seq_cnt got=%h exp=%h", fetch_cnt, cnt_exp(2)); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (dr !== 32'h8 || if_ins !== 32'h2222_2222 || if_pc !== 32'h4 || if_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d] got dr=%h ins=%h pc=%h v=%b exp 8/22222222/4/1", i, dr, if_ins, if_pc, if_valid);
      end
    end
    stall = 1'b0;
    step();
    total++; if (if_pc !== 32'h8 || if_ins !== 32'hC000_0002 || dr !== 32'hC)
      begin bad++; $display("FAIL stall_resume got pc=%h ins=%h dr=%h exp 8/C0000002/C", if_pc, if_ins, dr); end
    total++; if (fetch_cnt !== cnt_exp(3)) begin bad++; $display("FAIL stall_cnt got=%h exp=%h", fetch_cnt, cnt_exp(3)); end
  endtask

  task automatic test_branch();
    br_en = 1'b1; br_tgt = 32'h40; stall = 1'b1;
    step();
    total++; if (dr !== 32'h40 || if_valid !== 1'b0 || addr_err !== 1'b0)
      begin bad++; $display("FAIL br_redirect got dr=%h v=%b err=%b exp 40/0/0", dr, if_valid, addr_err); end
    total++; if (if_pc !== 32'h8) begin bad++; $display("FAIL br_flush_keep_pc got=%h exp=8", if_pc); end
    br_en = 1'b0; stall = 1'b0;
    step();
    total++; if (if_pc !== 32'h40 || if_valid !== 1'b1 || if_ins !== 32'hC000_0010 || dr !== 32'h44)
      begin bad++; $display("FAIL br_target_fetch got pc=%h v=%b ins=%h dr=%h exp 40/1/C0000010/44", if_pc, if_valid, if_ins, dr); end
    total++; if (fetch_cnt !== cnt_exp(4)) begin bad++; $display("FAIL br_cnt got=%h exp=%h", fetch_cnt, cnt_exp(4)); end
  endtask

  task automatic test_misaligned();
    br_en = 1'b1; br_tgt = 32'h42;
    step();
    total++; if (dr !== 32'h40 || addr_err !== 1'b1 || if_valid !== 1'b0)
      begin bad++; $display("FAIL mis_detect got dr=%h err=%b v=%b exp 40/1/0", dr, addr_err, if_valid); end
    br_en = 1'b0;
    step();
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL mis_pulse_width got err=%b exp=0", addr_err); end
    total++; if (if_pc !== 32'h40 || if_valid !== 1'b1 || dr !== 32'h44)
      begin bad++; $display("FAIL mis_fetch got pc=%h v=%b dr=%h exp 40/1/44", if_pc, if_valid, dr); end
  endtask

  task automatic test_halt();
    br_en = 1'b1; br_tgt = 32'd996;
    step();
    br_en = 1'b0;
    step();
    total++; if (if_pc !== 32'd996 || if_ins !== 32'hC000_00F9 || if_valid !== 1'b1 || halted !== 1'b0)
      begin bad++; $display("FAIL halt_last_word got pc=%h ins=%h v=%b h=%b exp 3e4/C00000F9/1/0", if_pc, if_ins, if_valid, halted); end
    total++; if (dr !== 32'd1000) begin bad++; $display("FAIL halt_dr_pre got=%h exp=3e8", dr); end
    step();
    total++; if (addr_err !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0 || dr !== 32'd1000)
      begin bad++; $display("FAIL halt_enter got err=%b h=%b v=%b dr=%h exp 1/1/0/3e8", addr_err, halted, if_valid, dr); end
    total++; if (if_pc !== 32'd996) begin bad++; $display("FAIL halt_keep_pc got=%h exp=3e4", if_pc); end
    step();
    total++; if (addr_err !== 1'b0 || halted !== 1'b1 || dr !== 32'd1000)
      begin bad++; $display("FAIL halt_stay got err=%b h=%b dr=%h exp 0/1/3e8", addr_err, halted, dr); end
    total++; if (fetch_cnt !== cnt_exp(6)) begin bad++; $display("FAIL halt_cnt got=%h exp=%h", fetch_cnt, cnt_exp(6)); end
    br_en = 1'b1; br_tgt = 32'h0;
    step();
    total++; if (halted !== 1'b0 || dr !== 32'h0 || addr_err !== 1'b0)
      begin bad++; $display("FAIL halt_exit got h=%b dr=%h err=%b exp 0/0/0", halted, dr, addr_err); end
    br_en = 1'b0;
    step();
    total++; if (if_pc !== 32'h0 || if_ins !== 32'h1111_1111 || if_valid !== 1'b1 || dr !== 32'h4)
      begin bad++; $display("FAIL halt_restart got pc=%h ins=%h v=%b dr=%h exp 0/11111111/1/4", if_pc, if_ins, if_valid, dr); end
    total++; if (fetch_cnt !== cnt_exp(7)) begin bad++; $display("FAIL restart_cnt got=%h exp=%h", fetch_cnt, cnt_exp(7)); end
  endtask

  task automatic test_no_wrap_and_reset();
    br_en = 1'b1; br_tgt = 32'hFFFF_FFFC;
    step();
    br_en = 1'b0;
    total++; if (dr !== 32'hFFFF_FFFC || halted !== 1'b0)
      begin bad++; $display("FAIL wrap_redirect got dr=%h h=%b exp FFFFFFFC/0", dr, halted); end
    step();
    total++; if (halted !== 1'b1 || addr_err !== 1'b1 || if_valid !== 1'b0)
      begin bad++; $display("FAIL wrap_halt got h=%b err=%b v=%b exp 1/1/0", halted, addr_err, if_valid); end
    stall = 1'b1; rst = 1'b1;
    step();
    total++; if (halted !== 1'b0 || dr !== 32'h0 || if_valid !== 1'b0 || addr_err !== 1'b0 || if_pc !== 32'h0 || if_ins !== 32'h0)
      begin bad++; $display("FAIL reset_mid_halt got h=%b dr=%h v=%b err=%b pc=%h ins=%h exp all 0", halted, dr, if_valid, addr_err, if_pc, if_ins); end
    total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL reset_mid_halt_cnt got=%h exp=0", fetch_cnt); end
    rst = 1'b0; stall = 1'b0;
    step();
    total++; if (if_ins !== 32'h1111_1111 || if_valid !== 1'b1 || dr !== 32'h4)
      begin bad++; $display("FAIL post_reset_fetch got ins=%h v=%b dr=%h exp 11111111/1/4", if_ins, if_valid, dr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 + 32'(i);
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    rst = 1'b1; stall = 1'b0; br_en = 1'b0; br_tgt = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misaligned();
    test_halt();
    test_no_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
